huffman_code_assigner: RTL and testbench

Canonical Huffman code generator for the deflate encoder path, the transmit-side counterpart of the inflate tree builder. It accepts one code length per symbol, counts lengths, and computes per-length start codes per RFC 1951 §3.2.2. It then assigns a canonical code to every symbol into an internal code table. The bit packer reads `{code, length}` per symbol from that table.

---
 rtl/huffman_pkg.sv | 25 ++
 rtl/huffman_code_ram.sv | 30 +++
 rtl/huffman_code_assigner.sv | 200 ++++++++++++++++++++
 tb/tb_huffman_code_assigner.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/huffman_pkg.sv
// Shared constants, FSM encoding and elaboration helpers for the canonical
// Huffman code assigner.
package huffman_pkg;

  localparam int HUFF_LIT_CODES  = 288;
  localparam int HUFF_DIST_CODES = 32;
  localparam int HUFF_MAX_BITS   = 15;
  localparam int HUFF_LEN_BITS   = 5;

  typedef enum logic [2:0] {
    HUFF_IDLE   = 3'd0,
    HUFF_LOAD   = 3'd1,
    HUFF_SCAN   = 3'd2,
    HUFF_ASSIGN = 3'd3,
    HUFF_DONE   = 3'd4
  } huff_asg_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/huffman_code_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port
// whose output register clears on reset.
module huffman_code_ram
  import huffman_pkg::*;
#(
  parameter int DEPTH = HUFF_LIT_CODES,
  parameter int AW    = 9,
  parameter int DW    = HUFF_LEN_BITS
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rdata <= '0;
    else       rdata <= mem[raddr];
  end

endmodule

// File: rtl/huffman_code_assigner.sv
// Canonical Huffman code assigner: counts code lengths, derives start codes and
// fills a {code, len} table. Define HUFFMAN_CODE_BITREV_EN to store codes bit-reversed.
module huffman_code_assigner
  import huffman_pkg::*;
#(
  parameter int NUMCODES  = HUFF_LIT_CODES,
  parameter int CODEBITS  = HUFF_LEN_BITS,
  parameter int BITLENGTH = HUFF_MAX_BITS,
  localparam int AW       = clog2(NUMCODES)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 istart,
  input  logic                 wren,
  input  logic [AW-1:0]        wraddr,
  input  logic [CODEBITS-1:0]  wrdata,
  input  logic                 run,
  output logic                 done,
  output logic                 err,
  input  logic [AW-1:0]        rdaddr,
  output logic [BITLENGTH-1:0] rdcode,
  output logic [CODEBITS-1:0]  rdlen
);

  localparam int CW   = BITLENGTH + 1;
  localparam int IW   = clog2(BITLENGTH + 1);
  localparam int CNTW = AW + 1;
  localparam int TW   = BITLENGTH + CODEBITS;

  localparam logic [2:0] S_IDLE   = HUFF_IDLE;
  localparam logic [2:0] S_LOAD   = HUFF_LOAD;
  localparam logic [2:0] S_SCAN   = HUFF_SCAN;
  localparam logic [2:0] S_ASSIGN = HUFF_ASSIGN;
  localparam logic [2:0] S_DONE   = HUFF_DONE;

  logic [2:0]           state;
  logic [IW-1:0]        scan_idx;
  logic [CNTW-1:0]      cnt;
  logic [CW-1:0]        blcount  [0:BITLENGTH];
  logic [CW-1:0]        nextcode [0:BITLENGTH];

  logic                 wr_illegal;
  logic                 len_we;
  logic [CODEBITS-1:0]  len_wdata;
  logic [AW-1:0]        len_raddr;
  logic [CODEBITS-1:0]  len_rd;
  logic                 tab_we;
  logic [AW-1:0]        tab_waddr;
  logic [TW-1:0]        tab_wdata;
  logic [TW-1:0]        tab_rd;

  logic [CW-1:0]        nc_prev;
  logic [CW-1:0]        bc_prev;
  logic [CW-1:0]        bc_cur;
  logic [CW-1:0]        nc_new;
  logic [CW-1:0]        limit;
  logic                 oversub;
  logic [BITLENGTH-1:0] code_sel;
  logic [BITLENGTH-1:0] code_out;

  assign wr_illegal = wrdata > CODEBITS'(BITLENGTH);
  assign len_we     = (state == S_LOAD) && wren && !istart;
  assign len_wdata  = wr_illegal ? '0 : wrdata;
  assign len_raddr  = (cnt < CNTW'(NUMCODES)) ? AW'(cnt) : '0;

  // The length read is one cycle behind the counter, so entry cnt-1 is written.
  assign tab_we    = (state == S_ASSIGN) && (cnt != '0);
  assign tab_waddr = AW'(cnt - CNTW'(1));
  assign tab_wdata = {code_out, len_rd};

  assign rdcode = tab_rd[CODEBITS +: BITLENGTH];
  assign rdlen  = tab_rd[CODEBITS-1:0];

  always_comb begin
    nc_prev = '0;
    bc_prev = '0;
    bc_cur  = '0;
    for (int k = 1; k <= BITLENGTH; k++) begin
      if (scan_idx == IW'(k)) begin
        nc_prev = nextcode[k-1];
        bc_prev = (k == 1) ? '0 : blcount[k-1];
        bc_cur  = blcount[k];
      end
    end
    nc_new  = (nc_prev + bc_prev) << 1;
    limit   = CW'(1) << scan_idx;
    oversub = (nc_new + bc_cur) > limit;
  end

  always_comb begin
    code_sel = '0;
    for (int k = 1; k <= BITLENGTH; k++) begin
      if (len_rd == CODEBITS'(k)) code_sel = nextcode[k][BITLENGTH-1:0];
    end
  end

`ifdef HUFFMAN_CODE_BITREV_EN
  // Reverse within the low L bits so deflate can shift the code out LSB-first.
  always_comb begin
    code_out = '0;
    for (int i = 0; i < BITLENGTH; i++) begin
      for (int j = 0; j < BITLENGTH; j++) begin
        if (int'(len_rd) == i + j + 1) code_out[i] = code_sel[j];
      end
    end
  end
`else
  assign code_out = code_sel;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= S_IDLE;
      scan_idx <= '0;
      cnt      <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      for (int k = 0; k <= BITLENGTH; k++) begin
        blcount[k]  <= '0;
        nextcode[k] <= '0;
      end
    end else if (istart) begin
      state <= S_LOAD;
      done  <= 1'b0;
      err   <= 1'b0;
      for (int k = 0; k <= BITLENGTH; k++) blcount[k] <= '0;
    end else if (state != S_IDLE && state != S_LOAD && !run) begin
      // Counts and lengths survive an abort so the rebuild is identical.
      state <= S_LOAD;
      done  <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (wren) begin
            if (wr_illegal) err <= 1'b1;
            for (int k = 1; k <= BITLENGTH; k++) begin
              if (wrdata == CODEBITS'(k)) blcount[k] <= blcount[k] + CW'(1);
            end
          end
          if (run) begin
            state    <= S_SCAN;
            scan_idx <= IW'(1);
          end
        end
        S_SCAN: begin
          for (int k = 1; k <= BITLENGTH; k++) begin
            if (scan_idx == IW'(k)) nextcode[k] <= nc_new;
          end
          if (oversub) err <= 1'b1;
          if (scan_idx == IW'(BITLENGTH)) begin
            state <= S_ASSIGN;
            cnt   <= '0;
          end else begin
            scan_idx <= scan_idx + IW'(1);
          end
        end
        S_ASSIGN: begin
          if (tab_we) begin
            for (int k = 1; k <= BITLENGTH; k++) begin
              if (len_rd == CODEBITS'(k)) nextcode[k] <= nextcode[k] + CW'(1);
            end
          end
          if (cnt == CNTW'(NUMCODES)) state <= S_DONE;
          else                        cnt   <= cnt + CNTW'(1);
        end
        S_DONE:  done  <= 1'b1;
        default: state <= S_IDLE;
      endcase
    end
  end

  huffman_code_ram #(
    .DEPTH(NUMCODES),
    .AW   (AW),
    .DW   (CODEBITS)
  ) u_len_ram (
    .clk  (clk),
    .rstn (rstn),
    .we   (len_we),
    .waddr(wraddr),
    .wdata(len_wdata),
    .raddr(len_raddr),
    .rdata(len_rd)
  );

  huffman_code_ram #(
    .DEPTH(NUMCODES),
    .AW   (AW),
    .DW   (TW)
  ) u_tab_ram (
    .clk  (clk),
    .rstn (rstn),
    .we   (tab_we),
    .waddr(tab_waddr),
    .wdata(tab_wdata),
    .raddr(rdaddr),
    .rdata(tab_rd)
  );

endmodule

// File: tb/tb_huffman_code_assigner.sv
// Scoreboard bench for huffman_code_assigner: table reads are queued with their
// hand-computed codes and a negedge monitor compares them when the read lands.
module tb_huffman_code_assigner;

  localparam int NUMCODES  = 288;
  localparam int CODEBITS  = 5;
  localparam int BITLENGTH = 15;
  localparam int AW        = 9;

  localparam int RFC_CODE [0:8] = '{2, 3, 4, 5, 6, 0, 14, 15, 0};
  localparam int FIX_SYM  [0:7] = '{0, 143, 144, 255, 256, 279, 280, 287};
  localparam int FIX_CODE [0:7] = '{'h30, 'hBF, 'h190, 'h1FF, 'h00, 'h17, 'hC0, 'hC7};
  localparam int FIX_LEN  [0:7] = '{8, 8, 9, 9, 7, 7, 8, 8};

  logic                 clk    = 1'b0;
  logic                 rstn   = 1'b1;
  logic                 istart = 1'b0;
  logic                 wren   = 1'b0;
  logic                 run    = 1'b0;
  logic [AW-1:0]        wraddr = '0;
  logic [AW-1:0]        rdaddr = '0;
  logic [CODEBITS-1:0]  wrdata = '0;
  logic                 done;
  logic                 err;
  logic [BITLENGTH-1:0] rdcode;
  logic [CODEBITS-1:0]  rdlen;

  int n_pass  = 0;
  int n_total = 0;
  int lens [NUMCODES];

  typedef struct {
    string       name;
    logic [14:0] code;
    logic [4:0]  len;
  } rd_exp_t;

  rd_exp_t exp_q [$];
  logic    req   = 1'b0;
  logic    req_d = 1'b0;

  huffman_code_assigner dut (
    .clk   (clk),
    .rstn  (rstn),
    .istart(istart),
    .wren  (wren),
    .wraddr(wraddr),
    .wrdata(wrdata),
    .run   (run),
    .done  (done),
    .err   (err),
    .rdaddr(rdaddr),
    .rdcode(rdcode),
    .rdlen (rdlen)
  );

  always #5 clk = ~clk;

  always @(posedge clk) req_d <= req;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_total++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  function automatic logic [14:0] table_code(input logic [14:0] plain, input int len);
`ifdef HUFFMAN_CODE_BITREV_EN
    logic [14:0] r;
    r = '0;
    for (int i = 0; i < len; i++) r[i] = plain[len-1-i];
    return r;
`else
    return plain & 15'((1 << len) - 1);
`endif
  endfunction

  // A read issued on one negedge is registered by the next posedge.
  always @(negedge clk) begin
    rd_exp_t e;
    if (req_d) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("[TB] FAIL read.unexpected: got code 0x%0h, expected no read", rdcode);
      end else begin
        e = exp_q.pop_front();
        check_output({e.name, ".code"}, 32'(rdcode), 32'(e.code));
        check_output({e.name, ".len"}, 32'(rdlen), 32'(e.len));
      end
    end
  end

  task automatic do_istart(input bit with_write);
    @(negedge clk);
    istart = 1'b1;
    run    = 1'b0;
    wren   = with_write;
    wraddr = '0;
    wrdata = 5'd1;
    @(negedge clk);
    istart = 1'b0;
    wren   = 1'b0;
  endtask

  task automatic apply_stimulus(input bit run_with_last);
    for (int i = 0; i < NUMCODES; i++) begin
      @(negedge clk);
      wren   = 1'b1;
      wraddr = AW'(i);
      wrdata = CODEBITS'(lens[i]);
      if (run_with_last && i == NUMCODES - 1) run = 1'b1;
    end
  endtask

  task automatic raise_run();
    @(negedge clk);
    wren = 1'b0;
    run  = 1'b1;
  endtask

  task automatic measure_build(output int cyc);
    cyc = -1;
    for (int c = 0; c < 1000 && cyc < 0; c++) begin
      @(negedge clk);
      wren = 1'b0;
      if (done === 1'b1) cyc = c;
    end
  endtask

  task automatic read_expect(input int addr, input int plain, input int len, input string name);
    @(negedge clk);
    rdaddr = AW'(addr);
    req    = 1'b1;
    exp_q.push_back('{name, table_code(15'(plain), len), 5'(len)});
  endtask

  task automatic end_reads();
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_rfc_lens();
    for (int i = 0; i < NUMCODES; i++) lens[i] = 0;
    lens[0] = 3; lens[1] = 3; lens[2] = 3; lens[3] = 3;
    lens[4] = 3; lens[5] = 2; lens[6] = 4; lens[7] = 4;
  endtask

  initial begin
    int cyc;
    int hi_cnt;

    #2 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset.done", 32'(done), 32'd0);
    check_output("reset.err", 32'(err), 32'd0);
    check_output("reset.rdcode", 32'(rdcode), 32'd0);
    check_output("reset.rdlen", 32'(rdlen), 32'd0);
    rstn = 1'b1;

    // RFC example; the write paired with istart must not be counted
    $display("[TB] RFC 1951 example table");
    do_istart(1'b0);
    do_istart(1'b1);
    set_rfc_lens();
    apply_stimulus(1'b0);
    raise_run();
    measure_build(cyc);
    check_output("rfc.done_cycle", 32'(cyc), 32'd305);
    check_output("rfc.err", 32'(err), 32'd0);
    for (int i = 0; i < 9; i++)
      read_expect(i, RFC_CODE[i], lens[i], $sformatf("rfc.sym%0d", i));
    end_reads();

    $display("[TB] fixed literal table, run raised with last write");
    do_istart(1'b0);
    for (int i = 0; i < NUMCODES; i++)
      lens[i] = (i < 144) ? 8 : (i < 256) ? 9 : (i < 280) ? 7 : 8;
    apply_stimulus(1'b1);
    measure_build(cyc);
    check_output("fixed.done_cycle", 32'(cyc), 32'd305);
    check_output("fixed.err", 32'(err), 32'd0);
    for (int i = 0; i < 8; i++)
      read_expect(FIX_SYM[i], FIX_CODE[i], FIX_LEN[i], $sformatf("fixed.sym%0d", FIX_SYM[i]));
    end_reads();

    $display("[TB] abort at cycle 100 and rebuild");
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    check_output("abort.done_low", 32'(done), 32'd0);
    run    = 1'b1;
    hi_cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (done) hi_cnt++;
    end
    run = 1'b0;
    @(negedge clk);
    run = 1'b1;
    measure_build(cyc);
    check_output("abort.done_cycle", 32'(cyc), 32'd305);
    check_output("abort.early_done", 32'(hi_cnt), 32'd0);
    for (int i = 0; i < 8; i++)
      read_expect(FIX_SYM[i], FIX_CODE[i], FIX_LEN[i], $sformatf("abort.sym%0d", FIX_SYM[i]));
    end_reads();

    $display("[TB] oversubscribed lengths");
    do_istart(1'b0);
    for (int i = 0; i < NUMCODES; i++) lens[i] = (i < 3) ? 1 : 0;
    apply_stimulus(1'b0);
    raise_run();
    measure_build(cyc);
    check_output("oversub.done_cycle", 32'(cyc), 32'd305);
    check_output("oversub.err", 32'(err), 32'd1);
    do_istart(1'b0);
    check_output("istart.err_clear", 32'(err), 32'd0);
    check_output("istart.done_clear", 32'(done), 32'd0);

    $display("[TB] illegal length 20");
    set_rfc_lens();
    lens[9] = 20;
    apply_stimulus(1'b0);
    raise_run();
    measure_build(cyc);
    check_output("illegal.done_cycle", 32'(cyc), 32'd305);
    check_output("illegal.err", 32'(err), 32'd1);
    read_expect(9, 0, 0, "illegal.sym9");
    read_expect(0, 2, 3, "illegal.sym0");
    read_expect(7, 15, 4, "illegal.sym7");
    end_reads();

    $display("[TB] reset during ASSIGN");
    @(negedge clk);
    run    = 1'b0;
    rdaddr = '0;
    @(negedge clk);
    run = 1'b1;
    repeat (200) @(negedge clk);
    rstn = 1'b0;
    #1;
    check_output("midreset.done", 32'(done), 32'd0);
    check_output("midreset.err", 32'(err), 32'd0);
    check_output("midreset.rdcode", 32'(rdcode), 32'd0);
    check_output("midreset.rdlen", 32'(rdlen), 32'd0);
    @(negedge clk);
    rstn   = 1'b1;
    hi_cnt = 0;
    repeat (400) begin
      @(negedge clk);
      if (done) hi_cnt++;
    end
    check_output("midreset.no_done", 32'(hi_cnt), 32'd0);

    check_output("scoreboard.drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
